// File: rtl/mem_burst_reader_if.sv
// Bus bundle for mem_burst_reader: command port, streaming output port,
// status, and the memory read port.
//
// Handshake rules on both valid/ready pairs: a transfer happens on a rising
// clock edge where valid and ready are both high. Once a producer raises valid
// it holds valid and its payload stable until that transfer happens. valid
// never depends combinationally on ready.
//
// The slave modport is the burst reader itself. The master modport is
// everything around it: the command source, the consumer and the memory.
interface mem_burst_reader_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  // Command port
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;

  // Streaming output port
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  // Status
  logic          busy;

  // Memory read port (one-cycle read latency)
  logic [AW-1:0] mem_addr;
  logic          mem_ren;
  logic [DW-1:0] mem_dout;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, out_ready, mem_dout,
    input  cmd_ready, out_valid, out_data, out_last, busy, mem_addr, mem_ren
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, out_ready, mem_dout,
    output cmd_ready, out_valid, out_data, out_last, busy, mem_addr, mem_ren
  );
endinterface

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: takes a (start address, length) command, issues
// consecutive single-cycle reads to a 64-word scratch memory (addresses wrap
// modulo 64), and streams the returned words out through a 2-entry buffer,
// marking the final beat with out_last.
module mem_burst_reader #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_burst_reader_if.slave bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = 1;
  localparam logic [AW:0]   LEN_ONE  = 1;

  // Control state
  state_t        r_state;
  logic [AW-1:0] r_addr;      // next read address
  logic [AW:0]   r_remain;    // reads still to issue
  logic [AW:0]   r_len;       // length of the burst in progress
  logic [AW:0]   r_beat;      // beats already delivered to the consumer

  // Read pipeline and output buffer
  logic          r_pend;      // a read was issued last cycle; data is on mem_dout now
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_occ;

  logic          w_out_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_ren;
  logic          w_last;
  logic          w_accept;
  logic [2:0]    w_inflight;
  logic [2:0]    w_limit;
  logic [AW:0]   w_last_beat;

  assign w_out_valid = (r_occ != 2'd0);
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_push      = r_pend;

  // A new read is allowed only if, after this cycle's pop, the words already
  // buffered plus the one in flight leave a free slot for it. This is what
  // keeps the 2-entry buffer from overflowing under backpressure.
  assign w_inflight  = {1'b0, r_occ} + {2'b00, r_pend};
  assign w_limit     = 3'd2 + {2'b00, w_pop};
  assign w_ren       = (r_state == S_ISSUE) && (w_inflight < w_limit);

  assign w_last_beat = r_len - LEN_ONE;
  assign w_last      = w_out_valid && (r_beat == w_last_beat);

  // Zero-length commands are consumed in IDLE without starting a burst.
  assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid && (bus.cmd_len != '0);

  // Burst control FSM: accept commands, walk the address, and wait for the
  // last beat to leave.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_len    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= bus.cmd_addr;
            r_remain <= bus.cmd_len;
            r_len    <= bus.cmd_len;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_ren) begin
            r_addr   <= r_addr + ADDR_ONE;  // natural wrap 63 -> 0
            r_remain <= r_remain - LEN_ONE;
            if (r_remain == LEN_ONE) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Delivered-beat counter; it tells out_last which head entry ends the burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat <= '0;
    end else if (w_accept) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= r_beat + LEN_ONE;
    end
  end

  // Read-data capture into the 2-entry FIFO. Only cycles following an issued
  // read push; the memory's idle zero output is never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend   <= 1'b0;
      r_buf0   <= '0;
      r_buf1   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      r_pend <= w_ren;
      if (w_push) begin
        if (r_wr_ptr) begin
          r_buf1 <= bus.mem_dout;
        end else begin
          r_buf0 <= bus.mem_dout;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_rd_ptr ? r_buf1 : r_buf0;
  assign bus.out_last  = w_last;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_ren   = w_ren;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Testbench for mem_burst_reader: directed scenarios plus randomized bursts,
// checked against a burst-level reference model (expected beat queue built
// from the memory image, plus issue/outstanding accounting).
module tb_mem_burst_reader;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int LW = AW + 1;
  localparam int MW = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_burst_reader_if #(.AW(AW), .DW(DW)) bus ();
  logic [1:0] dbg_state;

  mem_burst_reader #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- memory model (one-cycle read latency) ----------------
  logic [DW-1:0] mem [MW];
  always @(posedge clk) begin
    bus.mem_dout <= (bus.mem_ren === 1'b1) ? mem[bus.mem_addr] : '0;
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0] exp_q[$];   // {last, data}
  int n_checks = 0;
  int n_errors = 0;

  // Owned by the main sequence
  int t_acc       = 0;
  int cur_addr    = 0;
  int cur_len     = 0;
  int base_issued = 0;
  int base_popped = 0;
  int rdy_mode    = 0;     // 0: always ready, 1: random, 2: drop 5 cycles after beat 2

  // Owned by the monitor
  int   tot_issued    = 0;
  int   tot_popped    = 0;
  int   first_ren_cyc = -1;
  int   first_val_cyc = -1;
  logic hold_prev     = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  logic mon_pop;
  logic [DW:0] mon_exp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      hold_prev  = 1'b0;
      tot_popped = tot_issued;   // in-flight data is abandoned
    end else begin
      mon_pop = bus.out_valid && bus.out_ready;
      check_eq("cmd_ready_vs_busy", bus.cmd_ready, !bus.busy);

      if (hold_prev) begin
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_data",  bus.out_data,  prev_data);
        check_eq("hold_last",  bus.out_last,  prev_last);
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;

      if (bus.out_valid && first_val_cyc <= t_acc) first_val_cyc = cyc;

      if (bus.mem_ren) begin
        if (first_ren_cyc <= t_acc) first_ren_cyc = cyc;
        check_eq("ren_within_len", (tot_issued - base_issued) < cur_len, 1);
        check_eq("mem_addr", bus.mem_addr, (cur_addr + tot_issued - base_issued) % MW);
        check_eq("outstanding_le2", ((tot_issued + 1) - (tot_popped + int'(mon_pop))) <= 2, 1);
        tot_issued++;
      end

      if (mon_pop) begin
        check_eq("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check_eq("beat_data", bus.out_data, mon_exp[DW-1:0]);
          check_eq("beat_last", bus.out_last, mon_exp[DW]);
        end
        tot_popped++;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  initial begin : ready_driver
    int drop_left;
    bit dropped;
    drop_left = 0;
    dropped   = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tot_popped - base_popped == 0) dropped = 1'b0;
      if (rdy_mode == 2 && !dropped && (tot_popped - base_popped) == 3) begin
        drop_left = 5;
        dropped   = 1'b1;
      end
      if (rdy_mode == 1) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else if (drop_left > 0) begin
        bus.out_ready = 1'b0;
        drop_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a command in the current cycle and record what the model expects.
  task automatic start_cmd(input int addr, input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = LW'(len);
    t_acc       = cyc;
    cur_addr    = addr;
    cur_len     = len;
    base_issued = tot_issued;
    base_popped = tot_popped;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({1'(i == len - 1), mem[(addr + i) % MW]});
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data",  bus.out_data,  0);
    check_eq("rst_out_last",  bus.out_last,  0);
    check_eq("rst_busy",      bus.busy,      0);
    check_eq("rst_mem_ren",   bus.mem_ren,   0);
    check_eq("rst_mem_addr",  bus.mem_addr,  0);
  endtask

  // Run one command to completion. junk: offer random commands while the
  // burst is in progress (they must be ignored). timed: out_ready is held
  // high, so latency and completion cycle are exact.
  task automatic run_cmd(input int addr, input int len, input bit junk, input bit timed);
    int done_cyc;
    bit done;
    @(posedge clk); #1;
    check_eq("cmd_ready_idle", bus.cmd_ready, 1);
    start_cmd(addr, len);
    done     = 1'b0;
    done_cyc = -1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (junk && exp_q.size() > 0) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_len   = LW'($urandom_range(1, 64));
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (!bus.busy) begin
        done     = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    check_eq("burst_done", done, 1);
    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("beat_count", tot_popped - base_popped, len);
    if (timed) begin
      if (len == 0) begin
        check_eq("len0_no_ren",   first_ren_cyc <= t_acc, 1);
        check_eq("len0_no_valid", first_val_cyc <= t_acc, 1);
        check_eq("len0_idle",     done_cyc, t_acc + 1);
      end else begin
        check_eq("first_ren_latency",   first_ren_cyc, t_acc + 1);
        check_eq("first_valid_latency", first_val_cyc, t_acc + 3);
        check_eq("burst_end_cycle",     done_cyc, t_acc + len + 3);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  a;
    int  l;
    bit  found;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    for (int i = 0; i < MW; i++) mem[i] = DW'(i + 'h100);

    // Reset values
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;

    // Single word
    mem[5] = 32'hA5A5_0005;
    rdy_mode = 0;
    run_cmd(5, 1, 1'b0, 1'b1);

    // 4-beat burst at full rate (beats 0x10A..0x10D)
    mem[5] = 32'h0000_0105;
    run_cmd(10, 4, 1'b0, 1'b1);

    // Wrap-around 62, 63, 0, 1
    run_cmd(62, 4, 1'b0, 1'b1);

    // Backpressure after beat 2
    rdy_mode = 2;
    run_cmd(0, 8, 1'b0, 1'b0);
    rdy_mode = 0;

    // Boundary lengths
    run_cmd(7, 0, 1'b0, 1'b1);
    run_cmd(20, 64, 1'b0, 1'b1);

    // Reset mid-burst: reset one cycle after beat 3 of a 16-beat burst
    for (int i = 0; i < MW; i++) mem[i] = $urandom;
    @(posedge clk); #1;
    start_cmd(30, 16);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      if (tot_popped - base_popped >= 4) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_beat3", found, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    cur_len = 0;
    @(negedge clk);
    check_reset_vals();
    run_cmd(0, 2, 1'b0, 1'b1);

    // Randomized bursts, with random backpressure and ignored busy commands
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < MW; i++) mem[i] = $urandom;
      rdy_mode = $urandom_range(0, 1);
      a = $urandom_range(0, MW - 1);
      case ($urandom_range(0, 9))
        0:       l = 0;
        1:       l = 64;
        default: l = $urandom_range(1, 20);
      endcase
      run_cmd(a, l, 1'b1, rdy_mode == 0);
    end

    rdy_mode = 0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Read-side burst initiator for the 64×32-bit synchronous scratch memory. It accepts a (start address, length) command and issues consecutive single-cycle memory reads, wrapping modulo 64. It captures the one-cycle-latency read data into a 2-entry buffer and streams it out on a valid/ready port with a last-beat marker. It sits between a consumer such as a DMA or compute stage and the memory's read port; the memory's write enable is owned elsewhere.

## Interface
- `AW`, 6: memory address width (64 words).
- `DW`, 32: data width.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  AW  start word address.
- `cmd_len`  in  AW+1  beat count, 0..64; 0 is a no-op.
- `out_valid`  out  1  buffer head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  DW  buffer head data.
- `out_last`  out  1  head is the final beat of the burst.
- `busy`  out  1  high whenever state ≠ IDLE.
- `mem_addr`  out  AW  to memory `addr`.
- `mem_ren`  out  1  to memory `ren`.
- `mem_dout`  in  DW  from memory `dout`; valid the cycle after `mem_ren`, zero otherwise.

One clock domain; reset is synchronous and active-high.

## Operation
- **States.**
  - IDLE: `cmd_ready`=1. On `cmd_valid`, the command is accepted.
    - `cmd_len`=0: stay in IDLE, produce no beats.
    - Otherwise: load the address counter with `cmd_addr` and the remaining-issue counter with `cmd_len`, then go to ISSUE.
  - ISSUE: issue reads. When the last read is issued, go to DRAIN.
  - DRAIN: no new reads. When the beat with `out_last` handshakes, go to IDLE.
- **Issue rule.** `mem_ren`=1 iff state=ISSUE and `occ + pend − pop < 2`, where:
  - `occ` is buffer occupancy (0..2);
  - `pend` is 1 if `mem_ren` was high last cycle;
  - `pop` = `out_valid && out_ready`.
  - On issue, the address counter increments modulo 64 (63→0) and remaining decrements.
- **Address output.** `mem_addr` is the address counter, driven combinationally. It holds its last value in IDLE and DRAIN.
- **Capture.** When `pend`=1, `mem_dout` is written into the buffer tail. The buffer never receives data in cycles with `pend`=0; the memory's zero output is ignored.
- **Beat tracking.** A separate delivered-beat counter drives `out_last`, which is high iff the head entry is beat `cmd_len`−1.
- **Buffer.** 2-entry FIFO. A push and a pop in the same cycle are both allowed. The issue rule guarantees the buffer cannot overflow.
- **Reset.** Reset at any time, including mid-burst, has the following effect:
  - returns to IDLE;
  - clears the buffer, `pend`, and all counters;
  - abandons in-flight data.
- **Commands while busy.** Not accepted; `cmd_ready`=0.

## Timing
- **Reset values.**
  - `cmd_ready`=1.
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `busy`=0, `mem_ren`=0, `mem_addr`=0.
- **Latency.** For a command accepted in cycle T:
  - first `mem_ren` in T+1;
  - memory data on `mem_dout` in T+2;
  - first `out_valid` in T+3.
- **Throughput.** With `out_ready` held high, one beat per cycle. An N-beat burst returns to IDLE in cycle T+N+3.
- **Backpressure.**
  - While `out_ready`=0, at most 2 reads are outstanding, counting buffered plus pending.
  - `mem_ren` stays low until a pop frees space.
  - `out_data` and `out_last` are stable while `out_valid && !out_ready`.
- **Handshakes.** `out_valid` does not depend on `out_ready`. `mem_ren` may depend combinationally on `out_ready`.
- **Next command.** The earliest next-command acceptance is the cycle after the last-beat handshake.

## Test plan
- **Single word.**
  - Stimulus: memory preloaded with word[5]=0xA5A5_0005; cmd addr=5, len=1; `out_ready`=1.
  - Required: one beat with data 0xA5A5_0005 and `out_last`=1, `out_valid` at T+3; `busy` falls at T+4.
- **4-beat burst at full rate.**
  - Stimulus: word[i]=i+0x100; cmd addr=10, len=4; `out_ready`=1.
  - Required: beats 0x10A..0x10D in consecutive cycles T+3..T+6; `out_last` only on 0x10D.
- **Wrap-around.**
  - Stimulus: cmd addr=62, len=4.
  - Required: `mem_addr` sequence 62, 63, 0, 1; data matches those words in that order.
- **Backpressure.**
  - Stimulus: len=8 from addr 0; drop `out_ready` for 5 cycles after beat 2.
  - Required: `mem_ren` low once 2 reads are outstanding; no beat lost or duplicated; all 8 beats in order.
- **Boundary lengths.**
  - Stimulus: len=0, then len=64 from addr 20.
  - Required: len=0 gives no `mem_ren` or `out_valid` and `busy` stays 0; len=64 delivers all 64 words in order 20..63, 0..19.
- **Reset mid-burst.**
  - Stimulus: assert `reset` 1 cycle after beat 3 of a len=16 burst.
  - Required: next cycle shows all outputs at reset values; a fresh cmd addr=0, len=2 completes with correct data.
